// File: rtl/fetch_stage_buf.sv
// Instruction-fetch front end: drives a 1-cycle-latency instruction SRAM and
// queues returned words with their PCs in a small buffer ahead of decode.
module fetch_stage_buf #(
  parameter logic [31:0] RESET_PC  = 32'hbfc00000,
  parameter int          INST_W    = 32,
  parameter int          BUF_DEPTH = 4,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_sram_en,
  output logic [31:0]       inst_sram_addr,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              de_allowin,
  output logic              fe_valid,
  output logic [31:0]       fe_pc,
  output logic [INST_W-1:0] fe_inst
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       pc_reg;
  logic [31:0]       req_pc_reg;
  logic              inflight_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [31:0]       pc_mem   [BUF_DEPTH];
  logic [INST_W-1:0] inst_mem [BUF_DEPTH];

  logic [CNT_W-1:0]  used;
  logic              issue;
  logic              push;
  logic              pop;

  // Credit check counts the outstanding read so the buffer can never overflow.
  assign used           = count_reg + CNT_W'(inflight_reg);
  assign issue          = resetn & ~br_taken & (used < CNT_W'(BUF_DEPTH));
  assign inst_sram_en   = issue;
  assign inst_sram_addr = pc_reg & ~32'h3;

  // A redirect in the response cycle squashes the returning word.
  assign push     = inflight_reg & ~br_taken;
  assign fe_valid = (count_reg != '0) & ~br_taken;
  assign pop      = fe_valid & de_allowin;
  assign fe_pc    = pc_mem[rd_ptr_reg];
  assign fe_inst  = inst_mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg       <= RESET_PC;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (br_taken) begin
      pc_reg       <= br_target & ~32'h3;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (issue) begin
        pc_reg     <= pc_reg + PC_STEP;
        req_pc_reg <= pc_reg;
      end
      inflight_reg <= issue;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
      inst_mem[wr_ptr_reg] <= inst_sram_rdata;
    end
  end

  // Writing into a full buffer would mean the credit check is broken.
  assert property (@(posedge clk) disable iff (!resetn)
    !(push && count_reg == CNT_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_fetch_stage_buf.sv
// Bench for fetch_stage_buf: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_stage_buf;

  localparam logic [31:0] KEY      = 32'h5a5a5a5a;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        br_taken;
  logic [31:0] br_target;
  logic        de_allowin;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage_buf #(
    .RESET_PC (RESET_PC),
    .INST_W   (32),
    .BUF_DEPTH(DEPTH),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .de_allowin     (de_allowin),
    .fe_valid       (fe_valid),
    .fe_pc          (fe_pc),
    .fe_inst        (fe_inst)
  );

  // Instruction memory: each word is its own address XOR KEY, one-cycle latency.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ KEY;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of buffered PCs, the fetch PC and one pending read.
  logic [31:0] m_q[$];
  logic [31:0] m_pc     = RESET_PC;
  logic [31:0] m_req_pc = '0;
  bit          m_inflight = 1'b0;

  always @(negedge clk) begin
    bit ev;
    bit ee;
    if (!resetn) begin
      check("model_rst_en", inst_sram_en, 0);
      check("model_rst_valid", fe_valid, 0);
      check("model_rst_pc", fe_pc, 0);
      check("model_rst_inst", fe_inst, 0);
      m_q.delete();
      m_pc       = RESET_PC;
      m_inflight = 1'b0;
    end else begin
      ev = (m_q.size() != 0) && !br_taken;
      ee = !br_taken && (m_q.size() + int'(m_inflight) < DEPTH);
      check("model_en", inst_sram_en, ee);
      if (ee) check("model_addr", inst_sram_addr, m_pc);
      check("model_valid", fe_valid, ev);
      if (ev) begin
        check("model_pc", fe_pc, m_q[0]);
        check("model_inst", fe_inst, m_q[0] ^ KEY);
      end
      if (br_taken) begin
        m_q.delete();
        m_inflight = 1'b0;
        m_pc       = br_target & ~32'h3;
      end else begin
        if (ev && de_allowin) begin
          $display("pop pc=%h inst=%h", fe_pc, fe_inst);
          void'(m_q.pop_front());
        end
        if (m_inflight) m_q.push_back(m_req_pc);
        m_inflight = ee;
        if (ee) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int          n_req;
    logic [31:0] last_addr;
    logic [31:0] first_addr;
    int          first_k;

    resetn     = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    de_allowin = 1'b1;

    // Reset values
    smp();
    check("rst_en", inst_sram_en, 0);
    check("rst_valid", fe_valid, 0);
    check("rst_pc", fe_pc, 0);
    check("rst_inst", fe_inst, 0);

    // Release with decode always ready
    adv(); resetn = 1'b1;
    smp();
    check("start_en0", inst_sram_en, 1);
    check("start_addr0", inst_sram_addr, 32'hbfc00000);
    check("start_valid0", fe_valid, 0);
    adv(); smp();
    check("start_addr1", inst_sram_addr, 32'hbfc00004);
    check("start_valid1", fe_valid, 0);
    adv(); smp();
    check("start_valid2", fe_valid, 1);
    check("start_pc2", fe_pc, 32'hbfc00000);
    check("start_inst2", fe_inst, 32'he59a5a5a);
    check("start_addr2", inst_sram_addr, 32'hbfc00008);
    adv(); smp();
    check("start_pc3", fe_pc, 32'hbfc00004);
    check("start_inst3", fe_inst, 32'he59a5a5e);
    repeat (6) adv();

    // Decode stalled from reset: exactly DEPTH requests, then hold
    resetn = 1'b0; de_allowin = 1'b0;
    adv(); adv(); resetn = 1'b1;
    n_req = 0;
    last_addr = '0;
    for (int k = 0; k < 6; k++) begin
      smp();
      if (inst_sram_en) begin
        n_req++;
        last_addr = inst_sram_addr;
      end
      adv();
    end
    check("stall_nreq", n_req, 4);
    check("stall_last_addr", last_addr, 32'hbfc0000c);
    smp();
    check("stall_en_off", inst_sram_en, 0);
    check("stall_head_pc", fe_pc, 32'hbfc00000);
    adv(); de_allowin = 1'b1;
    first_addr = '0;
    first_k = -1;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (inst_sram_en && first_k < 0) begin
        first_addr = inst_sram_addr;
        first_k = k;
      end
      adv();
    end
    check("resume_addr", first_addr, 32'hbfc00010);
    check("resume_cycle", first_k, 1);
    repeat (4) adv();

    // Redirect during a steady stream
    br_taken = 1'b1; br_target = 32'h80001000;
    smp();
    check("br_valid", fe_valid, 0);
    check("br_en", inst_sram_en, 0);
    adv(); br_taken = 1'b0;
    smp();
    check("br_addr0", inst_sram_addr, 32'h80001000);
    check("br_valid0", fe_valid, 0);
    adv(); smp();
    check("br_addr1", inst_sram_addr, 32'h80001004);
    check("br_valid1", fe_valid, 0);
    adv(); smp();
    check("br_head_valid", fe_valid, 1);
    check("br_head_pc", fe_pc, 32'h80001000);
    check("br_head_inst", fe_inst, 32'hda5a4a5a);
    repeat (3) adv();

    // Unaligned target is aligned down
    br_taken = 1'b1; br_target = 32'h80001002;
    smp();
    check("align_en", inst_sram_en, 0);
    adv(); br_taken = 1'b0;
    smp();
    check("align_addr", inst_sram_addr, 32'h80001000);
    adv(); adv(); smp();
    check("align_pc", fe_pc, 32'h80001000);
    repeat (3) adv();

    // Back-to-back redirects: the last target wins
    br_taken = 1'b1; br_target = 32'h00001000;
    adv(); br_target = 32'h00002000;
    adv(); br_taken = 1'b0;
    smp();
    check("b2b_addr", inst_sram_addr, 32'h00002000);
    adv(); adv(); smp();
    check("b2b_valid", fe_valid, 1);
    check("b2b_pc", fe_pc, 32'h00002000);
    check("b2b_inst", fe_inst, 32'h5a5a7a5a);
    repeat (3) adv();

    // Reset while 3 entries are buffered and one read is in flight
    br_taken = 1'b1; br_target = 32'h00400000; de_allowin = 1'b0;
    adv(); br_taken = 1'b0;
    repeat (4) adv();
    resetn = 1'b0;
    smp();
    check("midrst_valid", fe_valid, 0);
    check("midrst_en", inst_sram_en, 0);
    adv(); adv();
    resetn = 1'b1; de_allowin = 1'b1;
    smp();
    check("midrst_addr", inst_sram_addr, RESET_PC);
    adv(); adv(); smp();
    check("midrst_head_pc", fe_pc, RESET_PC);
    check("midrst_head_valid", fe_valid, 1);
    repeat (5) adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
